// File: rtl/cpu64_cache_pkg.sv
// Shared types and helpers for the L1 cache arrays: default geometry,
// width derivation, sweep FSM state encoding and tag parity.
package cpu64_cache_pkg;

   localparam int unsigned DEF_DATA_W = 64;
   localparam int unsigned DEF_TAG_W  = 52;
   localparam int unsigned DEF_WAYS   = 8;
   localparam int unsigned DEF_SETS   = 64;
   localparam int unsigned DEF_WORDS  = 8;
   localparam int unsigned PAR_MAX_W  = 256;

   typedef enum logic [0:0] {
      ARR_IDLE  = 1'b0,
      ARR_SWEEP = 1'b1
   } arr_state_e;

   // Index width for n entries; never below 1 so a port always exists
   function automatic int unsigned addr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned be_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Even parity bit over a zero-extended tag
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/cpu64_l1_cache_arrays_if.sv
// Request/response bundle between a cache controller (master) and the
// L1 data/tag/valid arrays (slave).
interface cpu64_l1_cache_arrays_if #(
   parameter int unsigned DATA_W = cpu64_cache_pkg::DEF_DATA_W,
   parameter int unsigned TAG_W  = cpu64_cache_pkg::DEF_TAG_W,
   parameter int unsigned WAYS   = cpu64_cache_pkg::DEF_WAYS,
   parameter int unsigned SETS   = cpu64_cache_pkg::DEF_SETS,
   parameter int unsigned WORDS  = cpu64_cache_pkg::DEF_WORDS
);
   localparam int unsigned IDX_W  = cpu64_cache_pkg::addr_w(SETS);
   localparam int unsigned WORD_W = cpu64_cache_pkg::addr_w(WORDS);
   localparam int unsigned WAY_W  = cpu64_cache_pkg::addr_w(WAYS);
   localparam int unsigned BE_W   = cpu64_cache_pkg::be_w(DATA_W);

   logic                     rd_req_i;
   logic [IDX_W-1:0]         rd_index_i;
   logic [WORD_W-1:0]        rd_word_i;
   logic [TAG_W-1:0]         rd_tag_i;
   logic                     req_ready_o;
   logic                     rd_valid_o;
   logic [WAYS*DATA_W-1:0]   rdata_way_flat_o;
   logic [WAYS*TAG_W-1:0]    tag_way_flat_o;
   logic [WAYS-1:0]          valid_way_o;
   logic [WAYS-1:0]          hit_way_oh_o;
   logic                     hit_o;
   logic [WAY_W-1:0]         hit_way_o;
   logic                     multi_hit_o;
   logic [WAYS-1:0]          tag_perr_o;
   logic                     wr_en_i;
   logic [WAY_W-1:0]         wr_way_i;
   logic [IDX_W-1:0]         wr_index_i;
   logic [WORD_W-1:0]        wr_word_i;
   logic [BE_W-1:0]          wr_be_i;
   logic [DATA_W-1:0]        wr_data_i;
   logic                     tag_we_i;
   logic [TAG_W-1:0]         tag_i;
   logic                     set_valid_i;
   logic                     inv_set_i;
   logic [IDX_W-1:0]         inv_index_i;
   logic                     inv_all_i;
   logic                     busy_o;
   logic                     inv_done_o;

   modport master (
      output rd_req_i, rd_index_i, rd_word_i, rd_tag_i,
             wr_en_i, wr_way_i, wr_index_i, wr_word_i, wr_be_i, wr_data_i,
             tag_we_i, tag_i, set_valid_i, inv_set_i, inv_index_i, inv_all_i,
      input  req_ready_o, rd_valid_o, rdata_way_flat_o, tag_way_flat_o,
             valid_way_o, hit_way_oh_o, hit_o, hit_way_o, multi_hit_o,
             tag_perr_o, busy_o, inv_done_o
   );

   modport slave (
      input  rd_req_i, rd_index_i, rd_word_i, rd_tag_i,
             wr_en_i, wr_way_i, wr_index_i, wr_word_i, wr_be_i, wr_data_i,
             tag_we_i, tag_i, set_valid_i, inv_set_i, inv_index_i, inv_all_i,
      output req_ready_o, rd_valid_o, rdata_way_flat_o, tag_way_flat_o,
             valid_way_o, hit_way_oh_o, hit_o, hit_way_o, multi_hit_o,
             tag_perr_o, busy_o, inv_done_o
   );

endinterface

// File: rtl/cpu64_l1_hit_encode.sv
// Combinational lookup resolve: per-way tag compare with parity check,
// one-hot hit, lowest-index encode and multi-hit detect.
module cpu64_l1_hit_encode
   import cpu64_cache_pkg::*;
#(
   parameter int unsigned TAG_W     = DEF_TAG_W,
   parameter int unsigned WAYS      = DEF_WAYS,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic [WAYS-1:0]         i_valid,
   input  logic [WAYS*TAG_W-1:0]   i_tag_flat,
   input  logic [WAYS-1:0]         i_par,
   input  logic [TAG_W-1:0]        i_cmp_tag,
   output logic [WAYS-1:0]         o_hit_oh_c,
   output logic                    o_hit_c,
   output logic [addr_w(WAYS)-1:0] o_hit_way_c,
   output logic                    o_multi_hit_c,
   output logic [WAYS-1:0]         o_tag_perr_c
);
   localparam int unsigned WAY_W = addr_w(WAYS);

   logic [TAG_W-1:0] w_tag;

   always_comb begin
      w_tag         = '0;
      o_hit_oh_c    = '0;
      o_tag_perr_c  = '0;
      o_hit_way_c   = '0;
      o_hit_c       = 1'b0;
      o_multi_hit_c = 1'b0;
      for (int w = 0; w < int'(WAYS); w++) begin
         w_tag           = i_tag_flat[w*TAG_W +: TAG_W];
         o_tag_perr_c[w] = PARITY_EN && i_valid[w] &&
                           (i_par[w] != even_parity(PAR_MAX_W'(w_tag)));
         o_hit_oh_c[w]   = i_valid[w] && (w_tag == i_cmp_tag) && !o_tag_perr_c[w];
      end
      // Descending scan so the lowest hitting way is the one left behind
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (o_hit_oh_c[w]) o_hit_way_c = WAY_W'(w);
      end
      o_hit_c       = |o_hit_oh_c;
      o_multi_hit_c = |(o_hit_oh_c & (o_hit_oh_c - WAYS'(1)));
   end

endmodule

// File: rtl/cpu64_l1_cache_arrays.sv
// L1 data/tag/valid arrays with a registered lookup port, byte-enabled
// writes, per-way tag parity and a set-by-set invalidate-all sweep.
module cpu64_l1_cache_arrays
   import cpu64_cache_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned TAG_W     = DEF_TAG_W,
   parameter int unsigned WAYS      = DEF_WAYS,
   parameter int unsigned SETS      = DEF_SETS,
   parameter int unsigned WORDS     = DEF_WORDS,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   cpu64_l1_cache_arrays_if.slave   bus
);
   localparam int unsigned IDX_W = addr_w(SETS);
   localparam int unsigned BE_W  = be_w(DATA_W);

   logic [DATA_W-1:0] r_data  [SETS][WAYS][WORDS];
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [WAYS-1:0]   r_par   [SETS];
   logic [WAYS-1:0]   r_valid [SETS];

   arr_state_e        r_state;
   logic [IDX_W-1:0]  r_cnt;
   logic              r_inv_done;

   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rdata [WAYS];
   logic [TAG_W-1:0]  r_tag_q [WAYS];
   logic [WAYS-1:0]   r_par_q;
   logic [WAYS-1:0]   r_valid_q;
   logic [TAG_W-1:0]  r_cmp_tag;

   logic                   w_busy;
   logic                   w_accept;
   logic [WAYS*DATA_W-1:0] w_rdata_flat;
   logic [WAYS*TAG_W-1:0]  w_tag_flat;

   assign w_busy   = (r_state == ARR_SWEEP);
   assign w_accept = !w_busy;

   // Invalidate-all sweep: one set per cycle, done pulse on return to idle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ARR_IDLE;
         r_cnt      <= '0;
         r_inv_done <= 1'b0;
      end else begin
         r_inv_done <= 1'b0;
         case (r_state)
            ARR_IDLE: begin
               if (bus.inv_all_i) begin
                  r_state <= ARR_SWEEP;
                  r_cnt   <= '0;
               end
            end
            ARR_SWEEP: begin
               r_cnt <= r_cnt + IDX_W'(1);
               if (r_cnt == IDX_W'(SETS - 1)) begin
                  r_state    <= ARR_IDLE;
                  r_inv_done <= 1'b1;
               end
            end
            default: r_state <= ARR_IDLE;
         endcase
      end
   end

   // Valid bits; inv_set is applied after tag_we so invalidate wins
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < int'(SETS); s++) r_valid[s] <= '0;
      end else if (w_busy) begin
         r_valid[r_cnt] <= '0;
      end else begin
         if (bus.tag_we_i) r_valid[bus.wr_index_i][bus.wr_way_i] <= bus.set_valid_i;
         if (bus.inv_set_i) r_valid[bus.inv_index_i] <= '0;
      end
   end

   // Data, tag and parity storage; deliberately not reset
   always_ff @(posedge clk_i) begin
      if (w_accept && bus.wr_en_i) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (bus.wr_be_i[b])
               r_data[bus.wr_index_i][bus.wr_way_i][bus.wr_word_i][b*8 +: 8] <=
                  bus.wr_data_i[b*8 +: 8];
         end
      end
      if (w_accept && bus.tag_we_i) begin
         r_tag[bus.wr_index_i][bus.wr_way_i] <= bus.tag_i;
         r_par[bus.wr_index_i][bus.wr_way_i] <=
            PARITY_EN ? even_parity(PAR_MAX_W'(bus.tag_i)) : 1'b0;
      end
   end

   // Lookup stage samples pre-write contents, giving read-first behaviour
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_valid <= 1'b0;
         r_par_q    <= '0;
         r_valid_q  <= '0;
         r_cmp_tag  <= '0;
         for (int w = 0; w < int'(WAYS); w++) begin
            r_rdata[w] <= '0;
            r_tag_q[w] <= '0;
         end
      end else begin
         r_rd_valid <= w_accept && bus.rd_req_i;
         if (w_accept && bus.rd_req_i) begin
            r_cmp_tag <= bus.rd_tag_i;
            r_valid_q <= r_valid[bus.rd_index_i];
            r_par_q   <= r_par[bus.rd_index_i];
            for (int w = 0; w < int'(WAYS); w++) begin
               r_rdata[w] <= r_data[bus.rd_index_i][w][bus.rd_word_i];
               r_tag_q[w] <= r_tag[bus.rd_index_i][w];
            end
         end
      end
   end

   for (genvar w = 0; w < int'(WAYS); w++) begin : g_flat
      assign w_rdata_flat[w*DATA_W +: DATA_W] = r_rdata[w];
      assign w_tag_flat[w*TAG_W +: TAG_W]     = r_tag_q[w];
   end

   cpu64_l1_hit_encode #(
      .TAG_W     (TAG_W),
      .WAYS      (WAYS),
      .PARITY_EN (PARITY_EN)
   ) u_hit_encode (
      .i_valid       (r_valid_q),
      .i_tag_flat    (w_tag_flat),
      .i_par         (r_par_q),
      .i_cmp_tag     (r_cmp_tag),
      .o_hit_oh_c    (bus.hit_way_oh_o),
      .o_hit_c       (bus.hit_o),
      .o_hit_way_c   (bus.hit_way_o),
      .o_multi_hit_c (bus.multi_hit_o),
      .o_tag_perr_c  (bus.tag_perr_o)
   );

   assign bus.req_ready_o      = w_accept;
   assign bus.busy_o           = w_busy;
   assign bus.inv_done_o       = r_inv_done;
   assign bus.rd_valid_o       = r_rd_valid;
   assign bus.rdata_way_flat_o = w_rdata_flat;
   assign bus.tag_way_flat_o   = w_tag_flat;
   assign bus.valid_way_o      = r_valid_q;

endmodule

// File: tb/tb_cpu64_l1_cache_arrays.sv
// Self-checking bench for cpu64_l1_cache_arrays: directed scenarios plus
// random traffic against an array-level behavioural model.
module tb_cpu64_l1_cache_arrays;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned TAG_W  = 52;
   localparam int unsigned WAYS   = 8;
   localparam int unsigned SETS   = 64;
   localparam int unsigned WORDS  = 8;
   localparam int unsigned BE     = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cpu64_l1_cache_arrays_if bus_if ();

   cpu64_l1_cache_arrays dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model storage
   bit                m_valid  [SETS][WAYS];
   logic [TAG_W-1:0]  m_tag    [SETS][WAYS];
   bit                m_badpar [SETS][WAYS];
   logic [DATA_W-1:0] m_data   [SETS][WAYS][WORDS];
   bit   [BE-1:0]     m_dknown [SETS][WAYS][WORDS];
   bit                m_busy;
   int                m_sweep_set;

   // Model view of the registered lookup outputs
   bit                e_rd_valid;
   bit                e_done;
   logic [WAYS-1:0]   e_valid;
   logic [WAYS-1:0]   e_bad;
   logic [TAG_W-1:0]  e_tag   [WAYS];
   logic [DATA_W-1:0] e_data  [WAYS];
   bit   [BE-1:0]     e_dmask [WAYS];
   logic [TAG_W-1:0]  e_cmp;

   function automatic logic [WAYS-1:0] exp_hit_oh();
      logic [WAYS-1:0] r;
      r = '0;
      for (int w = 0; w < int'(WAYS); w++)
         r[w] = e_valid[w] && !e_bad[w] && (e_tag[w] == e_cmp);
      return r;
   endfunction

   function automatic logic [2:0] exp_hit_way();
      logic [WAYS-1:0] oh;
      oh = exp_hit_oh();
      for (int w = 0; w < int'(WAYS); w++)
         if (oh[w]) return 3'(w);
      return 3'd0;
   endfunction

   task automatic drive_idle();
      bus_if.rd_req_i    = 1'b0; bus_if.rd_index_i = '0; bus_if.rd_word_i = '0;
      bus_if.rd_tag_i    = '0;   bus_if.wr_en_i    = 1'b0; bus_if.wr_way_i = '0;
      bus_if.wr_index_i  = '0;   bus_if.wr_word_i  = '0;   bus_if.wr_be_i  = '0;
      bus_if.wr_data_i   = '0;   bus_if.tag_we_i   = 1'b0; bus_if.tag_i    = '0;
      bus_if.set_valid_i = 1'b0; bus_if.inv_set_i  = 1'b0; bus_if.inv_index_i = '0;
      bus_if.inv_all_i   = 1'b0;
   endtask

   // One clock: capture inputs, advance the model by the behavioural rules
   task automatic tick();
      bit r, rd, we, tw, sv, iv, ia;
      int ri, rw, wi, ww, wd, ii;
      logic [TAG_W-1:0]  rt, tg;
      logic [BE-1:0]     be;
      logic [DATA_W-1:0] dat;
      r  = rst;              rd = bus_if.rd_req_i;   we = bus_if.wr_en_i;
      tw = bus_if.tag_we_i;  sv = bus_if.set_valid_i; iv = bus_if.inv_set_i;
      ia = bus_if.inv_all_i;
      ri = int'(bus_if.rd_index_i); rw = int'(bus_if.rd_word_i); rt = bus_if.rd_tag_i;
      wi = int'(bus_if.wr_index_i); ww = int'(bus_if.wr_way_i);
      wd = int'(bus_if.wr_word_i);  be = bus_if.wr_be_i; dat = bus_if.wr_data_i;
      tg = bus_if.tag_i;            ii = int'(bus_if.inv_index_i);
      @(posedge clk);
      if (r) begin
         for (int s = 0; s < int'(SETS); s++)
            for (int w = 0; w < int'(WAYS); w++) m_valid[s][w] = 1'b0;
         m_busy = 1'b0; e_rd_valid = 1'b0; e_done = 1'b0;
         e_valid = '0; e_bad = '0; e_cmp = '0;
         for (int w = 0; w < int'(WAYS); w++) begin
            e_tag[w] = '0; e_data[w] = '0; e_dmask[w] = '1;
         end
      end else if (m_busy) begin
         e_rd_valid = 1'b0; e_done = 1'b0;
         for (int w = 0; w < int'(WAYS); w++) m_valid[m_sweep_set][w] = 1'b0;
         m_sweep_set++;
         if (m_sweep_set == int'(SETS)) begin
            m_busy = 1'b0; e_done = 1'b1;
         end
      end else begin
         e_done = 1'b0; e_rd_valid = rd;
         if (rd) begin
            e_cmp = rt;
            for (int w = 0; w < int'(WAYS); w++) begin
               e_valid[w] = m_valid[ri][w];
               e_bad[w]   = m_badpar[ri][w];
               e_tag[w]   = m_tag[ri][w];
               e_data[w]  = m_data[ri][w][rw];
               e_dmask[w] = m_dknown[ri][w][rw];
            end
         end
         if (we)
            for (int b = 0; b < int'(BE); b++)
               if (be[b]) begin
                  m_data[wi][ww][wd][b*8 +: 8] = dat[b*8 +: 8];
                  m_dknown[wi][ww][wd][b] = 1'b1;
               end
         if (tw) begin
            m_tag[wi][ww] = tg; m_badpar[wi][ww] = 1'b0; m_valid[wi][ww] = sv;
         end
         if (iv)
            for (int w = 0; w < int'(WAYS); w++) m_valid[ii][w] = 1'b0;
         if (ia) begin
            m_busy = 1'b1; m_sweep_set = 0;
         end
      end
      #1;
   endtask

   task automatic do_tag(input int s, input int w, input logic [TAG_W-1:0] t, input bit v);
      bus_if.tag_we_i = 1'b1; bus_if.wr_index_i = 6'(s); bus_if.wr_way_i = 3'(w);
      bus_if.tag_i = t; bus_if.set_valid_i = v;
      tick(); drive_idle();
   endtask

   task automatic do_write(input int s, input int w, input int wd,
                           input logic [DATA_W-1:0] d, input logic [BE-1:0] be);
      bus_if.wr_en_i = 1'b1; bus_if.wr_index_i = 6'(s); bus_if.wr_way_i = 3'(w);
      bus_if.wr_word_i = 3'(wd); bus_if.wr_data_i = d; bus_if.wr_be_i = be;
      tick(); drive_idle();
   endtask

   task automatic do_lookup(input int s, input int wd, input logic [TAG_W-1:0] t);
      bus_if.rd_req_i = 1'b1; bus_if.rd_index_i = 6'(s); bus_if.rd_word_i = 3'(wd);
      bus_if.rd_tag_i = t;
      tick(); drive_idle();
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      n_checks++;
      if (bus_if.rd_valid_o !== 1'b0 || bus_if.busy_o !== 1'b0 || bus_if.inv_done_o !== 1'b0)
         $display("FAIL reset_ctrl got rdv=%b busy=%b done=%b exp 0/0/0",
                  bus_if.rd_valid_o, bus_if.busy_o, bus_if.inv_done_o);
      else n_pass++;
      n_checks++;
      if (bus_if.req_ready_o !== 1'b1 || bus_if.valid_way_o !== 8'h00 || bus_if.hit_o !== 1'b0)
         $display("FAIL reset_out got rdy=%b vld=%h hit=%b exp 1/00/0",
                  bus_if.req_ready_o, bus_if.valid_way_o, bus_if.hit_o);
      else n_pass++;
      do_lookup(5, 3, 52'h123);
      n_checks++;
      if (bus_if.rd_valid_o !== 1'b1 || bus_if.valid_way_o !== 8'h00 || bus_if.hit_o !== 1'b0)
         $display("FAIL lookup_empty got rdv=%b vld=%h hit=%b exp 1/00/0",
                  bus_if.rd_valid_o, bus_if.valid_way_o, bus_if.hit_o);
      else n_pass++;
      tick();
      n_checks++;
      if (bus_if.rd_valid_o !== 1'b0)
         $display("FAIL rd_valid_pulse got %b exp 0", bus_if.rd_valid_o);
      else n_pass++;
   endtask

   task automatic test_write_hit();
      bus_if.tag_we_i = 1'b1; bus_if.wr_en_i = 1'b1;
      bus_if.wr_index_i = 6'd5; bus_if.wr_way_i = 3'd2; bus_if.wr_word_i = 3'd3;
      bus_if.tag_i = 52'h123; bus_if.set_valid_i = 1'b1;
      bus_if.wr_data_i = 64'hDEADBEEF_CAFEF00D; bus_if.wr_be_i = 8'hFF;
      tick(); drive_idle();
      do_lookup(5, 3, 52'h123);
      n_checks++;
      if (bus_if.hit_way_oh_o !== 8'h04 || bus_if.hit_way_o !== 3'd2 || bus_if.hit_o !== 1'b1)
         $display("FAIL hit_way2 got oh=%h way=%0d hit=%b exp 04/2/1",
                  bus_if.hit_way_oh_o, bus_if.hit_way_o, bus_if.hit_o);
      else n_pass++;
      n_checks++;
      if (bus_if.rdata_way_flat_o[2*DATA_W +: DATA_W] !== 64'hDEADBEEF_CAFEF00D)
         $display("FAIL rdata_full got %h exp deadbeefcafef00d",
                  bus_if.rdata_way_flat_o[2*DATA_W +: DATA_W]);
      else n_pass++;
      do_write(5, 2, 3, 64'h0000_0000_0000_00AA, 8'h01);
      do_lookup(5, 3, 52'h123);
      n_checks++;
      if (bus_if.rdata_way_flat_o[2*DATA_W +: DATA_W] !== 64'hDEADBEEF_CAFEF0AA)
         $display("FAIL rdata_be got %h exp deadbeefcafef0aa",
                  bus_if.rdata_way_flat_o[2*DATA_W +: DATA_W]);
      else n_pass++;
   endtask

   task automatic test_multi_hit();
      do_tag(9, 1, 52'h123, 1'b1);
      do_tag(9, 6, 52'h123, 1'b1);
      do_lookup(9, 0, 52'h123);
      n_checks++;
      if (bus_if.hit_way_oh_o !== 8'h42 || bus_if.hit_way_o !== 3'd1 || bus_if.multi_hit_o !== 1'b1)
         $display("FAIL multi_hit got oh=%h way=%0d multi=%b exp 42/1/1",
                  bus_if.hit_way_oh_o, bus_if.hit_way_o, bus_if.multi_hit_o);
      else n_pass++;
   endtask

   task automatic test_parity();
      dut.r_par[5][2] <= ~dut.r_par[5][2];
      m_badpar[5][2] = 1'b1;
      #1;
      do_lookup(5, 3, 52'h123);
      n_checks++;
      if (bus_if.tag_perr_o !== 8'h04 || bus_if.hit_o !== 1'b0)
         $display("FAIL parity got perr=%h hit=%b exp 04/0", bus_if.tag_perr_o, bus_if.hit_o);
      else n_pass++;
   endtask

   task automatic test_sweep();
      int busy_cnt, done_cnt, rdy_bad;
      do_tag(0, 3, 52'hA0, 1'b1);
      do_tag(10, 5, 52'hA1, 1'b1);
      do_tag(20, 0, 52'hA2, 1'b1);
      do_tag(63, 7, 52'hA3, 1'b1);
      bus_if.inv_all_i = 1'b1; tick(); drive_idle();
      busy_cnt = 0; done_cnt = 0; rdy_bad = 0;
      for (int c = 0; c < 90; c++) begin
         if (bus_if.busy_o === 1'b1) busy_cnt++;
         if (bus_if.req_ready_o !== !bus_if.busy_o) rdy_bad++;
         if (bus_if.inv_done_o === 1'b1) done_cnt++;
         if (c == 30) begin
            bus_if.tag_we_i = 1'b1; bus_if.wr_index_i = 6'd10; bus_if.wr_way_i = 3'd1;
            bus_if.tag_i = 52'hBB; bus_if.set_valid_i = 1'b1; bus_if.inv_all_i = 1'b1;
         end
         tick(); drive_idle();
      end
      n_checks++;
      if (busy_cnt != 64) $display("FAIL sweep_busy_len got %0d exp 64", busy_cnt);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || rdy_bad != 0)
         $display("FAIL sweep_done got done=%0d rdy_bad=%0d exp 1/0", done_cnt, rdy_bad);
      else n_pass++;
      foreach (e_valid[i]) begin end
      for (int k = 0; k < 4; k++) begin
         do_lookup((k == 0) ? 0 : (k == 1) ? 10 : (k == 2) ? 20 : 63, 0, 52'hA0);
         n_checks++;
         if (bus_if.valid_way_o !== 8'h00 || bus_if.valid_way_o !== e_valid)
            $display("FAIL sweep_valid k=%0d got %h exp 00", k, bus_if.valid_way_o);
         else n_pass++;
      end
      // Reset mid-sweep aborts without a done pulse
      do_tag(3, 2, 52'hC0, 1'b1);
      bus_if.inv_all_i = 1'b1; tick(); drive_idle();
      for (int c = 0; c < 20; c++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++;
      if (bus_if.busy_o !== 1'b0) $display("FAIL sweep_rst_busy got %b exp 0", bus_if.busy_o);
      else n_pass++;
      done_cnt = 0;
      for (int c = 0; c < 70; c++) begin
         if (bus_if.inv_done_o === 1'b1) done_cnt++;
         tick();
      end
      n_checks++;
      if (done_cnt != 0) $display("FAIL sweep_rst_done got %0d exp 0", done_cnt);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_tag(7, 0, 52'h777, 1'b1);
      bus_if.rd_req_i = 1'b1; bus_if.rd_index_i = 6'd7; bus_if.rd_tag_i = 52'h777;
      bus_if.tag_we_i = 1'b1; bus_if.wr_index_i = 6'd7; bus_if.wr_way_i = 3'd0;
      bus_if.tag_i = 52'h888; bus_if.set_valid_i = 1'b1;
      tick(); drive_idle();
      n_checks++;
      if (bus_if.tag_way_flat_o[TAG_W-1:0] !== 52'h777 || bus_if.hit_way_oh_o !== 8'h01)
         $display("FAIL rw_old got tag=%h oh=%h exp 777/01",
                  bus_if.tag_way_flat_o[TAG_W-1:0], bus_if.hit_way_oh_o);
      else n_pass++;
      do_lookup(7, 0, 52'h888);
      n_checks++;
      if (bus_if.tag_way_flat_o[TAG_W-1:0] !== 52'h888 || bus_if.hit_o !== 1'b1)
         $display("FAIL rw_new got tag=%h hit=%b exp 888/1",
                  bus_if.tag_way_flat_o[TAG_W-1:0], bus_if.hit_o);
      else n_pass++;
      bus_if.inv_set_i = 1'b1; bus_if.inv_index_i = 6'd7;
      bus_if.tag_we_i = 1'b1; bus_if.wr_index_i = 6'd7; bus_if.wr_way_i = 3'd0;
      bus_if.tag_i = 52'h999; bus_if.set_valid_i = 1'b1;
      tick(); drive_idle();
      do_lookup(7, 0, 52'h999);
      n_checks++;
      if (bus_if.valid_way_o[0] !== 1'b0 || bus_if.tag_way_flat_o[TAG_W-1:0] !== 52'h999)
         $display("FAIL inv_wins got vld0=%b tag=%h exp 0/999",
                  bus_if.valid_way_o[0], bus_if.tag_way_flat_o[TAG_W-1:0]);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] msk, act;
      for (int c = 0; c < 400; c++) begin
         bus_if.rd_req_i    = ($urandom_range(0, 1) == 1);
         bus_if.rd_index_i  = 6'($urandom_range(0, 3));
         bus_if.rd_word_i   = 3'($urandom_range(0, 7));
         bus_if.rd_tag_i    = 52'h100 + 52'($urandom_range(0, 3));
         bus_if.wr_en_i     = ($urandom_range(0, 9) < 3);
         bus_if.wr_index_i  = 6'($urandom_range(0, 3));
         bus_if.wr_way_i    = 3'($urandom_range(0, 7));
         bus_if.wr_word_i   = 3'($urandom_range(0, 7));
         bus_if.wr_be_i     = 8'($urandom);
         bus_if.wr_data_i   = {$urandom, $urandom};
         bus_if.tag_we_i    = ($urandom_range(0, 3) == 0);
         bus_if.tag_i       = 52'h100 + 52'($urandom_range(0, 3));
         bus_if.set_valid_i = ($urandom_range(0, 4) != 0);
         bus_if.inv_set_i   = ($urandom_range(0, 19) == 0);
         bus_if.inv_index_i = 6'($urandom_range(0, 3));
         bus_if.inv_all_i   = ($urandom_range(0, 99) == 0);
         tick();
         n_checks++;
         if (bus_if.rd_valid_o !== e_rd_valid || bus_if.busy_o !== m_busy ||
             bus_if.req_ready_o !== !m_busy || bus_if.inv_done_o !== e_done)
            $display("FAIL rnd_ctrl c=%0d got rdv=%b busy=%b rdy=%b done=%b exp %b/%b/%b/%b", c,
                     bus_if.rd_valid_o, bus_if.busy_o, bus_if.req_ready_o, bus_if.inv_done_o,
                     e_rd_valid, m_busy, !m_busy, e_done);
         else n_pass++;
         n_checks++;
         if (bus_if.valid_way_o !== e_valid || bus_if.tag_perr_o !== (e_valid & e_bad))
            $display("FAIL rnd_valid c=%0d got vld=%h perr=%h exp %h/%h", c,
                     bus_if.valid_way_o, bus_if.tag_perr_o, e_valid, e_valid & e_bad);
         else n_pass++;
         n_checks++;
         if (bus_if.hit_way_oh_o !== exp_hit_oh() || bus_if.hit_o !== (|exp_hit_oh()) ||
             bus_if.hit_way_o !== exp_hit_way() ||
             bus_if.multi_hit_o !== ($countones(exp_hit_oh()) > 1))
            $display("FAIL rnd_hit c=%0d got oh=%h way=%0d multi=%b exp oh=%h way=%0d", c,
                     bus_if.hit_way_oh_o, bus_if.hit_way_o, bus_if.multi_hit_o,
                     exp_hit_oh(), exp_hit_way());
         else n_pass++;
         for (int w = 0; w < int'(WAYS); w++) begin
            msk = '0;
            for (int b = 0; b < int'(BE); b++) if (e_dmask[w][b]) msk[b*8 +: 8] = 8'hFF;
            act = bus_if.rdata_way_flat_o[w*DATA_W +: DATA_W];
            n_checks++;
            if (((act ^ e_data[w]) & msk) !== '0 ||
                (e_valid[w] && bus_if.tag_way_flat_o[w*TAG_W +: TAG_W] !== e_tag[w]))
               $display("FAIL rnd_data c=%0d way=%0d got %h tag=%h exp %h tag=%h", c, w,
                        act, bus_if.tag_way_flat_o[w*TAG_W +: TAG_W], e_data[w], e_tag[w]);
            else n_pass++;
         end
      end
      drive_idle();
   endtask

   initial begin
      for (int s = 0; s < int'(SETS); s++)
         for (int w = 0; w < int'(WAYS); w++) begin
            m_tag[s][w] = '0;
            for (int d = 0; d < int'(WORDS); d++) m_data[s][w][d] = '0;
         end
      test_reset();
      test_write_hit();
      test_multi_hit();
      test_parity();
      test_sweep();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
